// File: rtl/axi4_reg_slice.sv
// Per-channel AXI4 register slice: bypass, forward (1 register) or full (2-entry skid) per channel.
// Latency: 0 cycles in bypass, 1 cycle in forward and full modes; full mode sustains 1 beat/cycle.
// Backpressure: bypass passes ready through; forward ready is combinational; full ready is registered.

module axi4_reg_slice_ch #(
    parameter int unsigned MODE = 2,
    parameter int unsigned PW   = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] in_payload,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] out_payload,
    output logic          occ_d
);

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

    state_t        state_q, state_d;
    logic          rdy_q, rdy_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] skid_q, skid_d;
    logic          push, pop;

    // Next-state, handshake and output selection for the configured mode.
    always_comb begin
        state_d     = state_q;
        head_d      = head_q;
        skid_d      = skid_q;
        rdy_d       = 1'b1;
        out_valid   = 1'b0;
        out_payload = head_q;
        in_ready    = 1'b0;
        push        = 1'b0;
        pop         = 1'b0;
        occ_d       = 1'b0;
        if (MODE == 0) begin
            out_valid   = in_valid;
            out_payload = in_payload;
            in_ready    = out_ready;
        end else if (MODE == 1) begin
            out_valid = (state_q != EMPTY);
            in_ready  = !out_valid || out_ready;
            push      = in_valid && in_ready;
            pop       = out_valid && out_ready;
            if (push) begin
                head_d  = in_payload;
                state_d = ONE;
            end else if (pop) begin
                state_d = EMPTY;
            end
            occ_d = (state_d != EMPTY);
        end else begin
            out_valid = (state_q != EMPTY);
            in_ready  = rdy_q;
            push      = in_valid && in_ready;
            pop       = out_valid && out_ready;
            case (state_q)
                EMPTY: begin
                    if (push) begin
                        head_d  = in_payload;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (push && !pop) begin
                        skid_d  = in_payload;
                        state_d = TWO;
                    end else if (pop && !push) begin
                        state_d = EMPTY;
                    end else if (push && pop) begin
                        // Old head leaves this edge, the new beat takes its place.
                        head_d = in_payload;
                    end
                end
                TWO: begin
                    // Ready was low, so only a pop can happen here.
                    if (pop) begin
                        head_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
            // Registered ready: high next cycle iff there will still be a free entry.
            rdy_d = (state_d != TWO);
            occ_d = (state_d != EMPTY);
        end
    end

    // Control state and registered ready; reset discards buffered beats.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= rdy_d;
        end
    end

    // Payload storage carries no reset; validity comes from the state only.
    always_ff @(posedge clk) begin
        head_q <= head_d;
        skid_q <= skid_d;
    end

endmodule

// AXI4 register slice top: five independent channel slices plus an aggregate busy flag.
// Latency: per channel, 0 (bypass) or 1 cycle (forward/full); busy is registered.
// Backpressure: each channel stalls independently; no state is shared between channels.

module axi4_reg_slice #(
    parameter int unsigned ID_W    = 4,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned USER_W  = 1,
    parameter int unsigned AW_MODE = 2,
    parameter int unsigned W_MODE  = 2,
    parameter int unsigned B_MODE  = 2,
    parameter int unsigned AR_MODE = 2,
    parameter int unsigned R_MODE  = 2,
    localparam int unsigned AX_PW  = ID_W + ADDR_W + 29 + USER_W,
    localparam int unsigned W_PW   = DATA_W + DATA_W / 8 + 1 + USER_W,
    localparam int unsigned B_PW   = ID_W + 2 + USER_W,
    localparam int unsigned R_PW   = ID_W + DATA_W + 3 + USER_W
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             s_aw_valid,
    output logic             s_aw_ready,
    input  logic [AX_PW-1:0] s_aw_payload,
    output logic             m_aw_valid,
    input  logic             m_aw_ready,
    output logic [AX_PW-1:0] m_aw_payload,
    input  logic             s_w_valid,
    output logic             s_w_ready,
    input  logic [W_PW-1:0]  s_w_payload,
    output logic             m_w_valid,
    input  logic             m_w_ready,
    output logic [W_PW-1:0]  m_w_payload,
    input  logic             m_b_valid,
    output logic             m_b_ready,
    input  logic [B_PW-1:0]  m_b_payload,
    output logic             s_b_valid,
    input  logic             s_b_ready,
    output logic [B_PW-1:0]  s_b_payload,
    input  logic             s_ar_valid,
    output logic             s_ar_ready,
    input  logic [AX_PW-1:0] s_ar_payload,
    output logic             m_ar_valid,
    input  logic             m_ar_ready,
    output logic [AX_PW-1:0] m_ar_payload,
    input  logic             m_r_valid,
    output logic             m_r_ready,
    input  logic [R_PW-1:0]  m_r_payload,
    output logic             s_r_valid,
    input  logic             s_r_ready,
    output logic [R_PW-1:0]  s_r_payload,
    output logic             busy
);

    logic aw_occ, w_occ, b_occ, ar_occ, r_occ;
    logic busy_q, busy_d;

    axi4_reg_slice_ch #(.MODE(AW_MODE), .PW(AX_PW)) u_aw (
        .clk(aclk), .rst_n(aresetn),
        .in_valid(s_aw_valid), .in_ready(s_aw_ready), .in_payload(s_aw_payload),
        .out_valid(m_aw_valid), .out_ready(m_aw_ready), .out_payload(m_aw_payload),
        .occ_d(aw_occ)
    );

    axi4_reg_slice_ch #(.MODE(W_MODE), .PW(W_PW)) u_w (
        .clk(aclk), .rst_n(aresetn),
        .in_valid(s_w_valid), .in_ready(s_w_ready), .in_payload(s_w_payload),
        .out_valid(m_w_valid), .out_ready(m_w_ready), .out_payload(m_w_payload),
        .occ_d(w_occ)
    );

    axi4_reg_slice_ch #(.MODE(B_MODE), .PW(B_PW)) u_b (
        .clk(aclk), .rst_n(aresetn),
        .in_valid(m_b_valid), .in_ready(m_b_ready), .in_payload(m_b_payload),
        .out_valid(s_b_valid), .out_ready(s_b_ready), .out_payload(s_b_payload),
        .occ_d(b_occ)
    );

    axi4_reg_slice_ch #(.MODE(AR_MODE), .PW(AX_PW)) u_ar (
        .clk(aclk), .rst_n(aresetn),
        .in_valid(s_ar_valid), .in_ready(s_ar_ready), .in_payload(s_ar_payload),
        .out_valid(m_ar_valid), .out_ready(m_ar_ready), .out_payload(m_ar_payload),
        .occ_d(ar_occ)
    );

    axi4_reg_slice_ch #(.MODE(R_MODE), .PW(R_PW)) u_r (
        .clk(aclk), .rst_n(aresetn),
        .in_valid(m_r_valid), .in_ready(m_r_ready), .in_payload(m_r_payload),
        .out_valid(s_r_valid), .out_ready(s_r_ready), .out_payload(s_r_payload),
        .occ_d(r_occ)
    );

    // Busy registers the next-cycle occupancy so it tracks the stored valid flags exactly.
    always_comb begin
        busy_d = aw_occ | w_occ | b_occ | ar_occ | r_occ;
    end

    // Busy flag register, cleared by reset.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            busy_q <= 1'b0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

endmodule

// File: tb/tb_axi4_reg_slice.sv
module tb_axi4_reg_slice;

    localparam int AXPW = 66;
    localparam int WPW  = 38;
    localparam int BPW  = 7;
    localparam int RPW  = 40;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    logic            s_aw_valid, s_aw_ready, m_aw_valid, m_aw_ready;
    logic [AXPW-1:0] s_aw_payload, m_aw_payload;
    logic            s_w_valid, s_w_ready, m_w_valid, m_w_ready;
    logic [WPW-1:0]  s_w_payload, m_w_payload;
    logic            m_b_valid, m_b_ready, s_b_valid, s_b_ready;
    logic [BPW-1:0]  m_b_payload, s_b_payload;
    logic            s_ar_valid, s_ar_ready, m_ar_valid, m_ar_ready;
    logic [AXPW-1:0] s_ar_payload, m_ar_payload;
    logic            m_r_valid, m_r_ready, s_r_valid, s_r_ready;
    logic [RPW-1:0]  m_r_payload, s_r_payload;
    logic            busy;

    axi4_reg_slice #(
        .ID_W(4), .ADDR_W(32), .DATA_W(32), .USER_W(1),
        .AW_MODE(2), .W_MODE(2), .B_MODE(0), .AR_MODE(2), .R_MODE(1)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready), .s_aw_payload(s_aw_payload),
        .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready), .m_aw_payload(m_aw_payload),
        .s_w_valid(s_w_valid), .s_w_ready(s_w_ready), .s_w_payload(s_w_payload),
        .m_w_valid(m_w_valid), .m_w_ready(m_w_ready), .m_w_payload(m_w_payload),
        .m_b_valid(m_b_valid), .m_b_ready(m_b_ready), .m_b_payload(m_b_payload),
        .s_b_valid(s_b_valid), .s_b_ready(s_b_ready), .s_b_payload(s_b_payload),
        .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_payload(s_ar_payload),
        .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_payload(m_ar_payload),
        .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_payload(m_r_payload),
        .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_payload(s_r_payload),
        .busy(busy)
    );

    int tests = 0;
    int failed = 0;
    bit cdone = 1'b0;
    bit rdone = 1'b0;

    logic [AXPW-1:0] q_aw[$];
    logic [WPW-1:0]  q_w[$];
    logic [BPW-1:0]  q_b[$];
    logic [AXPW-1:0] q_ar[$];
    logic [RPW-1:0]  q_r[$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic extra(input string nm, input logic [127:0] act);
        tests++;
        failed++;
        $display("FAIL %s_extra_beat: got %0h, expected no beat", nm, act);
    endtask

    task automatic timeout(input string nm);
        tests++;
        failed++;
        $display("FAIL %s_timeout: got no handshake, expected acceptance", nm);
    endtask

    // AW/AR: {id, addr, len, size, burst, lock, cache, prot, qos, region, user}
    function automatic logic [AXPW-1:0] mk_ax(input logic [3:0] id, input logic [31:0] addr,
                                               input logic [7:0] len);
        return {id, addr, len, 3'd2, 2'b01, 1'b0, 4'h3, 3'd0, 4'd0, 4'd0, 1'b1};
    endfunction

    // W: {data, strb, last, user}
    function automatic logic [WPW-1:0] mk_w(input int i, input logic last);
        logic [31:0] v;
        v = i;
        return {32'hA000_0000 + v, 4'hF, last, v[0]};
    endfunction

    // R: {id, data, resp, last, user}
    function automatic logic [RPW-1:0] mk_r(input int i);
        logic [31:0] v;
        v = i;
        return {v[3:0], v ^ 32'h5A5A_0000, v[1:0], (v[1:0] == 2'b11), v[2]};
    endfunction

    // Senders: entered just after a rising edge; expected beat queued at issue time.
    task automatic send_aw(input logic [AXPW-1:0] p);
        int n;
        n = 0;
        q_aw.push_back(p);
        s_aw_valid = 1'b1; s_aw_payload = p;
        @(negedge aclk);
        while (!s_aw_ready && n < 500) begin @(negedge aclk); n++; end
        if (!s_aw_ready) timeout("aw");
        @(posedge aclk); #1;
        s_aw_valid = 1'b0;
    endtask

    task automatic send_w(input logic [WPW-1:0] p);
        int n;
        n = 0;
        q_w.push_back(p);
        s_w_valid = 1'b1; s_w_payload = p;
        @(negedge aclk);
        while (!s_w_ready && n < 500) begin @(negedge aclk); n++; end
        if (!s_w_ready) timeout("w");
        @(posedge aclk); #1;
        s_w_valid = 1'b0;
    endtask

    task automatic send_b(input logic [BPW-1:0] p);
        int n;
        n = 0;
        q_b.push_back(p);
        m_b_valid = 1'b1; m_b_payload = p;
        @(negedge aclk);
        while (!m_b_ready && n < 500) begin @(negedge aclk); n++; end
        if (!m_b_ready) timeout("b");
        @(posedge aclk); #1;
        m_b_valid = 1'b0;
    endtask

    task automatic send_ar(input logic [AXPW-1:0] p);
        int n;
        n = 0;
        q_ar.push_back(p);
        s_ar_valid = 1'b1; s_ar_payload = p;
        @(negedge aclk);
        while (!s_ar_ready && n < 500) begin @(negedge aclk); n++; end
        if (!s_ar_ready) timeout("ar");
        @(posedge aclk); #1;
        s_ar_valid = 1'b0;
    endtask

    task automatic send_r(input logic [RPW-1:0] p);
        int n;
        n = 0;
        q_r.push_back(p);
        m_r_valid = 1'b1; m_r_payload = p;
        @(negedge aclk);
        while (!m_r_ready && n < 500) begin @(negedge aclk); n++; end
        if (!m_r_ready) timeout("r");
        @(posedge aclk); #1;
        m_r_valid = 1'b0;
    endtask

    // Monitors: pop and compare on every output handshake; check hold during stalls.
    bit aw_stall = 1'b0, w_stall = 1'b0, b_stall = 1'b0, ar_stall = 1'b0, r_stall = 1'b0;
    logic [AXPW-1:0] aw_prev, ar_prev;
    logic [WPW-1:0]  w_prev;
    logic [BPW-1:0]  b_prev;
    logic [RPW-1:0]  r_prev;

    always @(negedge aclk) begin
        if (!aresetn) aw_stall <= 1'b0;
        else begin
            if (aw_stall) begin
                chk("aw_stall_valid", m_aw_valid, 1'b1);
                chk("aw_stall_payload", m_aw_payload, aw_prev);
            end
            if (m_aw_valid && m_aw_ready) begin
                if (q_aw.size() == 0) extra("aw", m_aw_payload);
                else chk("aw_beat", m_aw_payload, q_aw.pop_front());
            end
            aw_stall <= m_aw_valid && !m_aw_ready;
            aw_prev  <= m_aw_payload;
        end
    end

    always @(negedge aclk) begin
        if (!aresetn) w_stall <= 1'b0;
        else begin
            if (w_stall) begin
                chk("w_stall_valid", m_w_valid, 1'b1);
                chk("w_stall_payload", m_w_payload, w_prev);
            end
            if (m_w_valid && m_w_ready) begin
                if (q_w.size() == 0) extra("w", m_w_payload);
                else chk("w_beat", m_w_payload, q_w.pop_front());
            end
            w_stall <= m_w_valid && !m_w_ready;
            w_prev  <= m_w_payload;
        end
    end

    always @(negedge aclk) begin
        if (!aresetn) b_stall <= 1'b0;
        else begin
            if (b_stall) begin
                chk("b_stall_valid", s_b_valid, 1'b1);
                chk("b_stall_payload", s_b_payload, b_prev);
            end
            if (s_b_valid && s_b_ready) begin
                if (q_b.size() == 0) extra("b", s_b_payload);
                else chk("b_beat", s_b_payload, q_b.pop_front());
            end
            b_stall <= s_b_valid && !s_b_ready;
            b_prev  <= s_b_payload;
        end
    end

    always @(negedge aclk) begin
        if (!aresetn) ar_stall <= 1'b0;
        else begin
            if (ar_stall) begin
                chk("ar_stall_valid", m_ar_valid, 1'b1);
                chk("ar_stall_payload", m_ar_payload, ar_prev);
            end
            if (m_ar_valid && m_ar_ready) begin
                if (q_ar.size() == 0) extra("ar", m_ar_payload);
                else chk("ar_beat", m_ar_payload, q_ar.pop_front());
            end
            ar_stall <= m_ar_valid && !m_ar_ready;
            ar_prev  <= m_ar_payload;
        end
    end

    always @(negedge aclk) begin
        if (!aresetn) r_stall <= 1'b0;
        else begin
            if (r_stall) begin
                chk("r_stall_valid", s_r_valid, 1'b1);
                chk("r_stall_payload", s_r_payload, r_prev);
            end
            if (s_r_valid && s_r_ready) begin
                if (q_r.size() == 0) extra("r", s_r_payload);
                else chk("r_beat", s_r_payload, q_r.pop_front());
            end
            r_stall <= s_r_valid && !s_r_ready;
            r_prev  <= s_r_payload;
        end
    end

    initial begin
        s_aw_valid = 0; s_aw_payload = '0; m_aw_ready = 0;
        s_w_valid = 0;  s_w_payload = '0;  m_w_ready = 0;
        m_b_valid = 0;  m_b_payload = '0;  s_b_ready = 0;
        s_ar_valid = 0; s_ar_payload = '0; m_ar_ready = 0;
        m_r_valid = 0;  m_r_payload = '0;  s_r_ready = 0;

        // Reset state
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        chk("rst_s_aw_ready", s_aw_ready, 1'b0);
        chk("rst_s_w_ready", s_w_ready, 1'b0);
        chk("rst_s_ar_ready", s_ar_ready, 1'b0);
        chk("rst_m_aw_valid", m_aw_valid, 1'b0);
        chk("rst_m_w_valid", m_w_valid, 1'b0);
        chk("rst_m_ar_valid", m_ar_valid, 1'b0);
        chk("rst_s_r_valid", s_r_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        @(posedge aclk); #1;
        aresetn = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        chk("post_rst_s_aw_ready", s_aw_ready, 1'b1);
        chk("post_rst_s_w_ready", s_w_ready, 1'b1);
        chk("post_rst_s_ar_ready", s_ar_ready, 1'b1);
        @(posedge aclk); #1;

        // Full AW: three beats against a stalled sink
        s_aw_valid = 1; s_aw_payload = mk_ax(4'h1, 32'h100, 8'd0); q_aw.push_back(s_aw_payload);
        @(negedge aclk); chk("aw_rdy_beat0", s_aw_ready, 1'b1);
        @(posedge aclk); #1;
        s_aw_payload = mk_ax(4'h2, 32'h104, 8'd1); q_aw.push_back(s_aw_payload);
        @(negedge aclk); chk("aw_rdy_beat1", s_aw_ready, 1'b1);
        @(posedge aclk); #1;
        s_aw_payload = mk_ax(4'h3, 32'h108, 8'd2); q_aw.push_back(s_aw_payload);
        @(negedge aclk);
        chk("aw_rdy_full", s_aw_ready, 1'b0);
        chk("aw_busy_full", busy, 1'b1);
        chk("aw_head_0x100", m_aw_payload, mk_ax(4'h1, 32'h100, 8'd0));
        @(posedge aclk); #1;
        @(negedge aclk); chk("aw_rdy_full_hold", s_aw_ready, 1'b0);
        @(posedge aclk); #1;
        m_aw_ready = 1;
        @(negedge aclk); chk("aw_rdy_registered", s_aw_ready, 1'b0);
        @(posedge aclk); #1;
        @(negedge aclk); chk("aw_third_accepted", s_aw_ready, 1'b1);
        @(posedge aclk); #1;
        s_aw_valid = 0;
        @(negedge aclk); chk("aw_last_out_valid", m_aw_valid, 1'b1);
        @(posedge aclk); #1;
        @(negedge aclk);
        chk("aw_drained", m_aw_valid, 1'b0);
        chk("aw_busy_idle", busy, 1'b0);
        @(posedge aclk); #1;

        // Full W: 16 back-to-back beats, last on beat 16
        m_w_ready = 1;
        for (int i = 0; i <= 16; i++) begin
            if (i < 16) begin
                s_w_valid = 1; s_w_payload = mk_w(i, i == 15); q_w.push_back(s_w_payload);
            end else begin
                s_w_valid = 0;
            end
            @(negedge aclk);
            if (i < 16) chk("w_in_ready", s_w_ready, 1'b1);
            chk("w_out_valid", m_w_valid, i > 0);
            @(posedge aclk); #1;
        end
        @(negedge aclk); chk("w_drained", m_w_valid, 1'b0);
        @(posedge aclk); #1;

        // Bypass B: same-cycle pass-through, busy unaffected
        s_b_ready = 1; m_b_valid = 1; m_b_payload = 7'b0011_10_0; q_b.push_back(7'b0011_10_0);
        @(negedge aclk);
        chk("b_same_cycle_valid", s_b_valid, 1'b1);
        chk("b_ready_through", m_b_ready, 1'b1);
        chk("b_busy", busy, 1'b0);
        @(posedge aclk); #1;
        m_b_valid = 0; s_b_ready = 0;
        @(negedge aclk);
        chk("b_valid_drop", s_b_valid, 1'b0);
        chk("b_ready_low", m_b_ready, 1'b0);
        chk("b_busy_after", busy, 1'b0);
        @(posedge aclk); #1;

        // Forward R: 1000 beats, random source gaps and sink stalls
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    repeat ($urandom_range(0, 1)) begin @(posedge aclk); #1; end
                    send_r(mk_r(i));
                end
                rdone = 1'b1;
            end
            begin
                while (!rdone) begin
                    @(posedge aclk); #1;
                    s_r_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        s_r_ready = 1;
        for (int n = 0; n < 100 && q_r.size() != 0; n++) @(posedge aclk);
        @(posedge aclk); #1;

        // Full AR: fill to two entries, then reset mid-transfer
        m_ar_ready = 0;
        s_ar_valid = 1; s_ar_payload = mk_ax(4'h5, 32'h200, 8'd0);
        @(posedge aclk); #1;
        s_ar_payload = mk_ax(4'h6, 32'h204, 8'd0);
        @(posedge aclk); #1;
        s_ar_valid = 0;
        @(negedge aclk);
        chk("ar_two_ready", s_ar_ready, 1'b0);
        chk("ar_two_valid", m_ar_valid, 1'b1);
        chk("ar_two_busy", busy, 1'b1);
        @(posedge aclk); #1;
        aresetn = 0;
        @(posedge aclk);
        @(negedge aclk);
        chk("ar_rst_valid", m_ar_valid, 1'b0);
        chk("ar_rst_ready", s_ar_ready, 1'b0);
        chk("ar_rst_busy", busy, 1'b0);
        @(posedge aclk); #1;
        aresetn = 1;
        @(posedge aclk);
        @(negedge aclk);
        chk("ar_release_ready", s_ar_ready, 1'b1);
        chk("ar_release_valid", m_ar_valid, 1'b0);
        @(posedge aclk); #1;

        // Concurrent traffic on all five channels with random sinks
        fork
            begin
                fork
                    for (int i = 0; i < 20; i++) begin
                        repeat ($urandom_range(0, 2)) begin @(posedge aclk); #1; end
                        send_aw(mk_ax(4'(i), 32'h2000 + 32'(i * 4), 8'(i)));
                    end
                    for (int i = 0; i < 20; i++) begin
                        repeat ($urandom_range(0, 2)) begin @(posedge aclk); #1; end
                        send_w(mk_w(i + 100, i == 19));
                    end
                    for (int i = 0; i < 20; i++) begin
                        repeat ($urandom_range(0, 2)) begin @(posedge aclk); #1; end
                        send_b({4'(i), 2'(i), 1'(i)});
                    end
                    for (int i = 0; i < 20; i++) begin
                        repeat ($urandom_range(0, 2)) begin @(posedge aclk); #1; end
                        send_ar(mk_ax(4'(i + 3), 32'h8000 + 32'(i * 64), 8'(i + 1)));
                    end
                    for (int i = 0; i < 20; i++) begin
                        repeat ($urandom_range(0, 2)) begin @(posedge aclk); #1; end
                        send_r(mk_r(i + 5000));
                    end
                join
                cdone = 1'b1;
            end
            begin
                while (!cdone) begin
                    @(posedge aclk); #1;
                    m_aw_ready = 1'($urandom_range(0, 1));
                    m_w_ready  = 1'($urandom_range(0, 1));
                    s_b_ready  = 1'($urandom_range(0, 1));
                    m_ar_ready = 1'($urandom_range(0, 1));
                    s_r_ready  = 1'($urandom_range(0, 1));
                end
            end
        join
        m_aw_ready = 1; m_w_ready = 1; s_b_ready = 1; m_ar_ready = 1; s_r_ready = 1;
        for (int n = 0; n < 200 && (q_aw.size() + q_w.size() + q_b.size() + q_ar.size() + q_r.size()) != 0; n++)
            @(posedge aclk);
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        chk("end_q_aw_empty", q_aw.size(), 0);
        chk("end_q_w_empty", q_w.size(), 0);
        chk("end_q_b_empty", q_b.size(), 0);
        chk("end_q_ar_empty", q_ar.size(), 0);
        chk("end_q_r_empty", q_r.size(), 0);
        chk("end_busy", busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/axi4_reg_slice.md
AXI4_REG_SLICE -- requirements
Module: axi4_reg_slice

Interface
REQ-001 SHALL have parameters (name, default, meaning), one per line as below.
  ID_W, 4, transaction ID width, all channels.
  ADDR_W, 32, AW/AR address width.
  DATA_W, 32, W/R data width; multiple of 8; strobe width is DATA_W/8.
  USER_W, 1, user-signal width, all channels.
  AW_MODE, W_MODE, B_MODE, AR_MODE, R_MODE, 2 each, per-channel mode: 0 = bypass, 1 = forward, 2 = full.
REQ-002 SHALL pack payloads LSB-last, in the order given.
  AW/AR: {id, addr, len[7:0], size[2:0], burst[1:0], lock[0:0], cache[3:0], prot[2:0], qos[3:0], region[3:0], user}.
  W: {data, strb, last, user}.
  B: {id, resp[1:0], user}.
  R: {id, data, resp[1:0], last, user}.
REQ-003 SHALL have these ports (name, direction, width, meaning), one per line:
  aclk  in  1  single clock; all logic on its rising edge.
  aresetn  in  1  synchronous, active-low reset.
  s_<ch>_valid / s_<ch>_payload / m_<ch>_ready  in  1 / PW / 1  upstream side, for ch in {aw, w, ar}.
  s_<ch>_ready / m_<ch>_valid / m_<ch>_payload  out  1 / 1 / PW  downstream side, for ch in {aw, w, ar}.
  m_<ch>_valid / m_<ch>_payload / s_<ch>_ready  in  1 / PW / 1  subordinate-side return, for ch in {b, r}.
  m_<ch>_ready / s_<ch>_valid / s_<ch>_payload  out  1 / 1 / PW  manager-side return, for ch in {b, r}.
  busy  out  1  high when any channel slice holds at least one beat.
REQ-004 SHALL define, for every channel, "in" as the side that sources valid and payload, and "out" as the side that sources valid toward the sink.

Function
REQ-005 SHALL instantiate, per channel, one independent slice selected by that channel's MODE; channels SHALL share no state.
REQ-006 Bypass mode SHALL tie out_valid = in_valid, out_payload = in_payload and in_ready = out_ready, with zero latency and no storage.
REQ-007 Forward mode SHALL use one payload register plus a valid flag.
  Load: on in_valid && in_ready.
  Combinational ready: in_ready = !out_valid || out_ready.
  Latency: 1 cycle; throughput: 1 beat per cycle.
REQ-008 Full mode SHALL be a 2-entry skid buffer with states EMPTY, ONE and TWO, and a registered in_ready that is high iff the next state is not TWO.
REQ-009 Full-mode transitions (push = in_valid && in_ready, pop = out_valid && out_ready):
  EMPTY: push -> ONE.
  ONE: push && !pop -> TWO; pop && !push -> EMPTY; both -> ONE.
  TWO: pop -> ONE; push cannot occur.
REQ-010 Full mode SHALL present the oldest entry on out_payload with out_valid = (state != EMPTY).
  Latency: 1 cycle; sustained throughput: 1 beat per cycle.
  No combinational path from out_ready to in_ready, or from in_valid to out_valid.
REQ-011 Each slice SHALL hold out_payload stable while out_valid && !out_ready, and SHALL never deassert out_valid before the handshake.
REQ-012 Each slice SHALL preserve beat order and never drop or duplicate a beat.
REQ-013 Simultaneous push and pop in state ONE SHALL keep exactly one valid entry, equal to the newly pushed beat once the old head is consumed.
REQ-014 busy SHALL be the registered OR of all forward/full slice valid flags; bypass channels SHALL contribute 0.
REQ-015 W, R last and all user fields SHALL pass through unmodified; the block SHALL NOT interpret burst fields.

Reset
REQ-016 While aresetn is sampled low at the aclk edge, every stored valid flag SHALL clear, full slices SHALL enter EMPTY, and busy SHALL go to 0.
REQ-017 During reset, all registered in_ready outputs SHALL be 0; they SHALL go to 1 on the first aclk edge with aresetn high. Payload registers are not reset.
REQ-018 A reset asserted mid-transfer SHALL discard all buffered beats, with no out_valid on the cycle after the reset edge.

Verification
REQ-019 Full AW: push addr 0x100, 0x104, 0x108 on consecutive cycles with m_aw_ready = 0 -> s_aw_ready drops after the 2nd beat; release ready -> 0x100, then 0x104 out, then 0x108 accepted.
REQ-020 Full W: continuous valid with ready always 1, 16 beats with wlast on beat 16 -> 16 beats out in 16 consecutive cycles after 1-cycle latency; last appears only on beat 16.
REQ-021 Forward R: random in_valid and out_ready over 1000 beats with incrementing data -> output sequence matches input, and payload is stable during every stall.
REQ-022 Bypass B: bid = 0x3, bresp = 2 -> appears on the same cycle; busy stays 0.
REQ-023 Reset with AR in state TWO -> cycle after reset edge: m_ar_valid = 0, s_ar_ready = 0 and busy = 0; s_ar_ready = 1 one cycle after release.
REQ-024 Concurrent traffic on all five channels with mixed modes -> no cross-channel interaction, and per-channel scoreboards are clean.
